// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - framed parallel-in serial-out transmitter
// Start bit, WIDTH data bits, optional even parity, stop bit; each bit held BIT_DIV clocks.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int BIT_DIV   = 1,
   parameter int MSB_FIRST = 0,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             data_out,
   output logic             busy,
   output logic             done
);

   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
   localparam logic [BW-1:0] BITS     = BW'(WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, state_nx;
   logic [DW-1:0]    div_cnt, div_nx;
   logic [BW-1:0]    bit_cnt, bit_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic             parity, parity_nx;
   logic             line_nx;
   logic             ser_bit;
   logic             div_last;
   logic             accept;

   assign div_last = (div_cnt == DIV_LAST);
   assign in_ready = (state == IDLE) || (state == STOP && div_last);
   assign done     = (state == STOP) && div_last;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_nx  = state;
      div_nx    = div_cnt;
      bit_nx    = bit_cnt;
      shreg_nx  = shreg;
      parity_nx = parity;
      ser_bit   = 1'b1;
      line_nx   = 1'b1;

      if (state != IDLE)
         div_nx = div_last ? '0 : div_cnt + DW'(1);

      case (state)
         IDLE:   ;
         START:  if (div_last) state_nx = DATA;
         DATA: begin
            if (div_last) begin
               shreg_nx = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
               bit_nx   = bit_cnt - BW'(1);
               if (bit_cnt == BW'(1))
                  state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: if (div_last) state_nx = STOP;
         STOP:   if (div_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // An accept in the final STOP clock overrides the return to IDLE: back-to-back frames.
      if (accept) begin
         state_nx  = START;
         div_nx    = '0;
         bit_nx    = BITS;
         shreg_nx  = in_data;
         parity_nx = ^in_data;
      end

      ser_bit = (MSB_FIRST != 0) ? shreg_nx[WIDTH-1] : shreg_nx[0];

      case (state_nx)
         START:   line_nx = 1'b0;
         DATA:    line_nx = ser_bit;
         PARITY:  line_nx = parity_nx;
         default: line_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         parity   <= 1'b0;
         data_out <= 1'b1;
      end else begin
         state    <= state_nx;
         div_cnt  <= div_nx;
         bit_cnt  <= bit_nx;
         shreg    <= shreg_nx;
         parity   <= parity_nx;
         data_out <= line_nx;
      end
   end

endmodule
